// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one word request at a time over req/ack,
// fixed access latency, pipeline stall while busy, error flag for bad addresses.
module dmem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic        ack_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(LATENCY + 1);
  localparam logic [31:0]   MAX_ADDR = 32'(4 * DEPTH - 4);
  localparam logic [CW-1:0] CNT_INIT = (LATENCY > 1) ? CW'(LATENCY - 2) : CW'(0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state_r, state_nxt_s;
  logic [CW-1:0]  cnt_r, cnt_nxt_s;
  logic           we_r;
  logic [AW-1:0]  addr_r;
  logic [31:0]    wdata_r;
  logic           ack_r, ack_nxt_s;
  logic           err_r, err_nxt_s;
  logic [31:0]    rdata_r;
  logic           cap_s, access_s, bad_s;
  logic           acc_we_s;
  logic [AW-1:0]  acc_idx_s;
  logic [31:0]    acc_wdata_s;
  logic [31:0]    mem_r [DEPTH];

  assign bad_s   = (addr_i[1:0] != 2'b00) || (addr_i > MAX_ADDR);
  assign stall_o = req_i & ~ack_r;
  assign ack_o   = ack_r;
  assign err_o   = err_r;
  assign rdata_o = rdata_r;

  // Next-state, handshake outputs and storage-access strobe
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    ack_nxt_s   = 1'b0;
    err_nxt_s   = 1'b0;
    cap_s       = 1'b0;
    access_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_i) begin
          cap_s = 1'b1;
          if (bad_s) begin
            state_nxt_s = RESP;
            ack_nxt_s   = 1'b1;
            err_nxt_s   = 1'b1;
          end else if (LATENCY == 1) begin
            state_nxt_s = RESP;
            ack_nxt_s   = 1'b1;
            access_s    = 1'b1;
          end else begin
            state_nxt_s = BUSY;
            cnt_nxt_s   = CNT_INIT;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUSY: begin
        if (cnt_r == CW'(0)) begin
          state_nxt_s = RESP;
          ack_nxt_s   = 1'b1;
          access_s    = 1'b1;
        end else begin
          cnt_nxt_s = cnt_r - CW'(1);
        end
      end
      RESP: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // The single-cycle build touches storage straight from the request inputs
  always_comb begin
    acc_we_s    = 1'b0;
    acc_idx_s   = '0;
    acc_wdata_s = 32'h0000_0000;
    if (state_r == IDLE) begin
      acc_we_s    = we_i;
      acc_idx_s   = addr_i[AW+1:2];
      acc_wdata_s = wdata_i;
    end else begin
      acc_we_s    = we_r;
      acc_idx_s   = addr_r;
      acc_wdata_s = wdata_r;
    end
  end

  // FSM state, counter, captured request and registered response
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= IDLE;
      cnt_r   <= CW'(0);
      we_r    <= 1'b0;
      addr_r  <= '0;
      wdata_r <= 32'h0000_0000;
      ack_r   <= 1'b0;
      err_r   <= 1'b0;
      rdata_r <= 32'h0000_0000;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      ack_r   <= ack_nxt_s;
      err_r   <= err_nxt_s;
      if (cap_s) begin
        we_r    <= we_i;
        addr_r  <= addr_i[AW+1:2];
        wdata_r <= wdata_i;
      end
      if (access_s && !acc_we_s) begin
        rdata_r <= mem_r[acc_idx_s];
      end
    end
  end

  // Storage array, deliberately not reset; a reset edge discards a pending store
  always_ff @(posedge clk_i) begin
    if (access_s && acc_we_s && !rst_i) begin
      mem_r[acc_idx_s] <= acc_wdata_s;
    end
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Multi-cycle data-memory responder. It sits at the memory end of the CPU's MEM-stage load/store interface and replaces the zero-latency combinational data memory.
- It accepts one word request at a time through a req/ack handshake and models a fixed access latency.
- While a request is in flight, it drives a stall that freezes the CPU pipeline.
- It flags misaligned and out-of-range accesses.

Parameters:
- DEPTH, 1024: number of 32-bit words in the storage array. Valid byte addresses are 0 .. 4*DEPTH-4.
- LATENCY, 4: cycles from request acceptance to ack_o for a legal access. Must be >= 1.

Ports:
- clk_i  input  1: single clock, all state on rising edge.
- rst_i  input  1: synchronous, active-high reset.
- req_i  input  1: request valid. Held high, with stable fields, until the cycle ack_o=1.
- we_i  input  1: 1 = store word, 0 = load word.
- addr_i  input  32: byte address.
- wdata_i  input  32: store data.
- stall_o  output  1: pipeline freeze, combinational: req_i & ~ack_o.
- ack_o  output  1: one-cycle completion pulse, registered.
- rdata_o  output  32: load result, registered, valid when ack_o=1 and held until the next load completes.
- err_o  output  1: qualifies ack_o. 1 = the access was rejected (misaligned or out of range).

Behaviour:
- One clock domain (clk_i); rst_i is synchronous and active-high.
- Reset values:
  - State = IDLE; ack_o=0; err_o=0; rdata_o=0; latency counter=0; captured request cleared.
  - Storage array contents are NOT cleared by reset.
- States: IDLE, BUSY, RESP.
- IDLE:
  - On req_i=1, capture we_i, addr_i and wdata_i into internal registers.
  - If addr_i[1:0]!=0 or addr_i > 4*DEPTH-4: set error flag, go to RESP next cycle. Total latency is 1; storage is untouched.
  - Else, if LATENCY==1: go to RESP next cycle.
  - Else: load counter with LATENCY-2 and go to BUSY.
- BUSY:
  - Decrement counter each cycle.
  - When counter==0, go to RESP.
  - The storage access occurs on that same edge:
    - store: write the captured wdata at word index addr[log2(DEPTH)+1:2];
    - load: read that word into rdata_o.
- RESP:
  - ack_o=1 and err_o=error flag for exactly this cycle.
  - Next state is IDLE. ack_o and err_o return to 0 next cycle.
- Request handling:
  - A new request can be accepted in the cycle after RESP, so back-to-back accesses are spaced LATENCY+1 cycles apart.
  - Inputs are sampled only in IDLE. Changes to req or its fields during BUSY/RESP are ignored; this is a protocol violation by the requester.
  - req_i dropping during BUSY does not abort the access.
- Stores:
  - rdata_o is unchanged by a store or by an errored access.
  - A load that follows a store to the same address returns the stored value.
- stall_o:
  - High from the first cycle req_i is seen through the cycle before ack_o.
  - Low in the ack cycle, so the CPU advances on that edge.
- Reset mid-operation: return to IDLE immediately. A pending store in BUSY is discarded (array not written), and no ack is issued.
- Address width rule: only addr bits [log2(DEPTH)+1:2] index the array. Upper bits participate only in the range check.

Test Plan:
1. Reset, then store addr=0x10, wdata=0xDEADBEEF, LATENCY=4:
   - ack_o is high 4 cycles after the req cycle, err_o=0;
   - stall_o is high for the 4 preceding cycles.
2. Load addr=0x10 immediately after test 1's ack: ack after 4 cycles, rdata_o=0xDEADBEEF; rdata_o stays 0xDEADBEEF after ack drops.
3. Misaligned load addr=0x13:
   - ack_o=1 and err_o=1 on the next cycle;
   - rdata_o unchanged;
   - a subsequent load of 0x10 still returns 0xDEADBEEF.
4. Out-of-range store addr=0x1000 with DEPTH=1024, wdata=0x1: ack with err_o=1 after 1 cycle; load of 0x0 returns its prior value.
5. Store addr=0x20, wdata=0x12345678, then assert rst_i in the 2nd BUSY cycle:
   - no ack_o pulse;
   - a later load of 0x20 returns the prior contents, not 0x12345678.
6. LATENCY=1 build, back-to-back store 0x4=0xA5A5A5A5 then load 0x4: each ack arrives 1 cycle after acceptance, and the load returns 0xA5A5A5A5.
